// File: rtl/target_scheduler_pkg.sv
// Shared definitions for the reflex-training target scheduler.
// Contents: FSM state encoding, LFSR width/taps/default seed, score ceiling,
// and a saturating score increment helper.
package target_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSpawn   = 2'd1,
        StArmed   = 2'd2,
        StHoldoff = 2'd3
    } state_e;

    localparam int unsigned LFSR_WIDTH = 16;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v >= SCORE_MAX) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 16-bit Galois LFSR used as the spawn position source.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset, loads SEED
//   lfsr - current LFSR state
module target_lfsr
    import target_scheduler_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [LFSR_WIDTH-1:0] lfsr
);

    logic [LFSR_WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_d;
        end
    end

endmodule

// File: rtl/target_scheduler.sv
// Target sequencer for one reflex-training round: spawns targets at
// pseudo-random positions, arms them for a fixed lifetime, and judges each
// trigger press as a hit or miss against the cursor.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start               - level, high while a round runs
//   trigger             - one-cycle trigger pulse
//   cursor_x/cursor_y   - crosshair position
//   ball_x/ball_y       - target centre
//   target_visible      - draw enable
//   hit_pulse/miss_pulse- one-cycle event strobes
//   hits/misses         - saturating scores (0..99)
//   state               - FSM state for debug
module target_scheduler
    import target_scheduler_pkg::*;
#(
    parameter int                    H_RES         = 640,
    parameter int                    V_RES         = 480,
    parameter int                    RADIUS        = 16,
    parameter int unsigned           LIFE_TICKS    = 100000000,
    parameter int unsigned           HOLDOFF_TICKS = 10000000,
    parameter int unsigned           MAX_RETRY     = 8,
    parameter logic [LFSR_WIDTH-1:0] SEED          = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       trigger,
    input  logic [9:0] cursor_x,
    input  logic [9:0] cursor_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       target_visible,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [6:0] hits,
    output logic [6:0] misses,
    output logic [1:0] state
);

    state_e                state_q, state_d;
    logic [9:0]            ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                  visible_q, visible_d, hit_q, hit_d, miss_q, miss_d;
    logic [6:0]            hits_q, hits_d, misses_q, misses_d;
    logic [31:0]           life_q, life_d, holdoff_q, holdoff_d, retry_q, retry_d;
    logic [LFSR_WIDTH-1:0] lfsr;

    target_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Spawn candidate and acceptance window.
    logic [9:0] cand_x, cand_y;
    logic       cand_ok;
    assign cand_x  = lfsr[9:0];
    assign cand_y  = {1'b0, lfsr[15:7]};
    assign cand_ok = (int'(cand_x) >= RADIUS) && (int'(cand_x) <= H_RES - 1 - RADIUS) &&
                     (int'(cand_y) >= RADIUS) && (int'(cand_y) <= V_RES - 1 - RADIUS) &&
                     ((cand_x != ball_x_q) || (cand_y != ball_y_q));

    // Square hitbox; 11-bit signed differences so edge targets never wrap.
    logic signed [10:0] dx, dy;
    logic        [10:0] adx, ady;
    logic               in_box;
    always_comb begin
        dx     = $signed({1'b0, cursor_x}) - $signed({1'b0, ball_x_q});
        dy     = $signed({1'b0, cursor_y}) - $signed({1'b0, ball_y_q});
        adx    = dx[10] ? 11'(-dx) : 11'(dx);
        ady    = dy[10] ? 11'(-dy) : 11'(dy);
        in_box = (int'(adx) <= RADIUS) && (int'(ady) <= RADIUS);
    end

    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        hits_d    = hits_q;
        misses_d  = misses_q;
        life_d    = life_q;
        holdoff_d = holdoff_q;
        retry_d   = retry_q;

        if (state_q != StIdle && !start) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        hits_d   = '0;
                        misses_d = '0;
                        retry_d  = '0;
                        state_d  = StSpawn;
                    end
                end
                StSpawn: begin
                    if (retry_q >= MAX_RETRY) begin
                        // Fallback alternates between quarter points so the
                        // position always changes.
                        ball_x_d = (ball_x_q != 10'(H_RES / 4)) ? 10'(H_RES / 4)
                                                                 : 10'(3 * H_RES / 4);
                        ball_y_d = 10'(V_RES / 2);
                        retry_d  = '0;
                        life_d   = '0;
                        state_d  = StArmed;
                    end else if (cand_ok) begin
                        ball_x_d = cand_x;
                        ball_y_d = cand_y;
                        retry_d  = '0;
                        life_d   = '0;
                        state_d  = StArmed;
                    end else begin
                        retry_d = retry_q + 32'd1;
                    end
                end
                StArmed: begin
                    life_d = life_q + 32'd1;
                    // A hit beats a simultaneous timeout.
                    if (trigger && in_box) begin
                        hit_d     = 1'b1;
                        hits_d    = sat_inc(hits_q);
                        holdoff_d = '0;
                        state_d   = StHoldoff;
                    end else if (life_q == LIFE_TICKS - 1) begin
                        miss_d   = 1'b1;
                        misses_d = sat_inc(misses_q);
                        state_d  = StSpawn;
                    end else if (trigger) begin
                        miss_d   = 1'b1;
                        misses_d = sat_inc(misses_q);
                    end
                end
                StHoldoff: begin
                    if (holdoff_q == HOLDOFF_TICKS - 1) begin
                        holdoff_d = '0;
                        state_d   = StSpawn;
                    end else begin
                        holdoff_d = holdoff_q + 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        visible_d = (state_d == StArmed);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ball_x_q  <= 10'(H_RES / 2);
            ball_y_q  <= 10'(V_RES / 2);
            visible_q <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            hits_q    <= '0;
            misses_q  <= '0;
            life_q    <= '0;
            holdoff_q <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            visible_q <= visible_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            hits_q    <= hits_d;
            misses_q  <= misses_d;
            life_q    <= life_d;
            holdoff_q <= holdoff_d;
            retry_q   <= retry_d;
        end
    end

    assign ball_x         = ball_x_q;
    assign ball_y         = ball_y_q;
    assign target_visible = visible_q;
    assign hit_pulse      = hit_q;
    assign miss_pulse     = miss_q;
    assign hits           = hits_q;
    assign misses         = misses_q;
    assign state          = state_q;

endmodule

// File: tb/tb_target_scheduler.sv
// Self-checking bench for target_scheduler: scoreboard of expected
// hit/miss events, plus a second instance with an impossible spawn window.
module tb_target_scheduler;

    localparam int LIFE = 50;
    localparam int HOLD = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, trigger;
    logic [9:0] cursor_x, cursor_y, ball_x, ball_y;
    logic       target_visible, hit_pulse, miss_pulse;
    logic [6:0] hits, misses;
    logic [1:0] state;

    logic       start_b, trigger_b;
    logic [9:0] cursor_x_b, cursor_y_b, ball_x_b, ball_y_b;
    logic       target_visible_b, hit_pulse_b, miss_pulse_b;
    logic [6:0] hits_b, misses_b;
    logic [1:0] state_b;

    target_scheduler #(
        .LIFE_TICKS    (LIFE),
        .HOLDOFF_TICKS (HOLD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .trigger        (trigger),
        .cursor_x       (cursor_x),
        .cursor_y       (cursor_y),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .target_visible (target_visible),
        .hit_pulse      (hit_pulse),
        .miss_pulse     (miss_pulse),
        .hits           (hits),
        .misses         (misses),
        .state          (state)
    );

    target_scheduler #(
        .RADIUS        (300),
        .LIFE_TICKS    (LIFE),
        .HOLDOFF_TICKS (HOLD)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .start          (start_b),
        .trigger        (trigger_b),
        .cursor_x       (cursor_x_b),
        .cursor_y       (cursor_y_b),
        .ball_x         (ball_x_b),
        .ball_y         (ball_y_b),
        .target_visible (target_visible_b),
        .hit_pulse      (hit_pulse_b),
        .miss_pulse     (miss_pulse_b),
        .hits           (hits_b),
        .misses         (misses_b),
        .state          (state_b)
    );

    typedef struct packed {
        logic       hp;
        logic       mp;
        logic [6:0] h;
        logic [6:0] m;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  exp_hits = 0;
    int  exp_misses = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Score model: predicts the event and counter values after one judgement.
    task automatic push_expect(input bit is_hit);
        ev_t e;
        if (is_hit) begin
            if (exp_hits < 99) exp_hits++;
        end else begin
            if (exp_misses < 99) exp_misses++;
        end
        e = {is_hit, ~is_hit, 7'(exp_hits), 7'(exp_misses)};
        sb.push_back(e);
    endtask

    task automatic wait_armed(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state == 2'd2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ball_x, ball_y, target_visible, hit_pulse, miss_pulse, hits, misses, state} !==
            {10'd320, 10'd240, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 2'd0}) begin
            failures++;
            $display("FAIL reset: ball=(%0d,%0d) vis=%b hp=%b mp=%b hits=%0d misses=%0d st=%0d required (320,240) 0 0 0 0 0 0",
                     ball_x, ball_y, target_visible, hit_pulse, miss_pulse, hits, misses, state);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({ball_x, ball_y, target_visible, hits, misses, state} !==
            {10'd320, 10'd240, 1'b0, 7'd0, 7'd0, 2'd0}) begin
            failures++;
            $display("FAIL reset_hold: ball=(%0d,%0d) vis=%b hits=%0d misses=%0d st=%0d required (320,240) 0 0 0 0",
                     ball_x, ball_y, target_visible, hits, misses, state);
        end
        rst = 1'b1;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic test_hit();
        bit ok;
        int bad;
        logic [9:0] bx, by;
        ev_t e, o;
        start = 1'b1;
        tick();
        wait_armed(40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL first_arm: state=%0d required 2", state); end
        checks++;
        if (target_visible !== 1'b1) begin
            failures++; $display("FAIL armed_visible: got %b required 1", target_visible);
        end
        bx = ball_x; by = ball_y;
        cursor_x = bx; cursor_y = by; trigger = 1'b1; push_expect(1'b1);
        tick();
        trigger = 1'b0;
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL hit_event: got %h required %h", o, e); end
        checks++;
        if (state !== 2'd3) begin failures++; $display("FAIL hit_to_holdoff: state=%0d required 3", state); end
        bad = 0;
        for (int i = 0; i < HOLD; i++) begin
            if (target_visible !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL holdoff_blank: visible cycles=%0d required 0", bad); end
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL holdoff_len: state=%0d required 1", state); end
        wait_armed(40, ok);
        checks++;
        if (!ok || ball_x < 16 || ball_x > 623 || ball_y < 16 || ball_y > 463 ||
            (ball_x == bx && ball_y == by)) begin
            failures++;
            $display("FAIL respawn_pos: ball=(%0d,%0d) prev=(%0d,%0d) required new in [16..623]x[16..463]",
                     ball_x, ball_y, bx, by);
        end
    endtask

    task automatic test_hitbox_edge();
        bit ok;
        logic [9:0] bx, by;
        ev_t e, o;
        cursor_x = ball_x + 10'd16; cursor_y = ball_y - 10'd16; trigger = 1'b1; push_expect(1'b1);
        tick();
        trigger = 1'b0;
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL edge16_hit: got %h required %h", o, e); end
        wait_armed(60, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL edge_rearm: state=%0d required 2", state); end
        bx = ball_x; by = ball_y;
        cursor_x = bx + 10'd17; cursor_y = by; trigger = 1'b1; push_expect(1'b0);
        tick();
        trigger = 1'b0;
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL edge17x_miss: got %h required %h", o, e); end
        checks++;
        if (state !== 2'd2 || ball_x !== bx || ball_y !== by || target_visible !== 1'b1) begin
            failures++;
            $display("FAIL miss_stays: state=%0d ball=(%0d,%0d) required 2 (%0d,%0d)", state, ball_x, ball_y, bx, by);
        end
        cursor_x = bx; cursor_y = by + 10'd17; trigger = 1'b1; push_expect(1'b0);
        tick();
        trigger = 1'b0;
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL edge17y_miss: got %h required %h", o, e); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        ev_t e, o;
        // Still armed from the misses: let it expire.
        push_expect(1'b0);
        n = 0;
        while (state == 2'd2 && n < 60) begin n++; tick(); end
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL timeout_a: got %h required %h", o, e); end
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL timeout_respawn: state=%0d required 1", state); end
        tick();
        checks++;
        if (miss_pulse !== 1'b0) begin failures++; $display("FAIL timeout_single: miss_pulse=%b required 0", miss_pulse); end
        wait_armed(20, ok);
        push_expect(1'b0);
        n = 0;
        while (state == 2'd2 && n < 60) begin n++; tick(); end
        checks++;
        if (!ok || n != LIFE) begin failures++; $display("FAIL life_len: armed cycles=%0d required %0d", n, LIFE); end
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL timeout_b: got %h required %h", o, e); end
        wait_armed(20, ok);
        cursor_x = ball_x; cursor_y = ball_y;
        for (int i = 0; i < LIFE - 1; i++) tick();
        trigger = 1'b1; push_expect(1'b1);
        tick();
        trigger = 1'b0;
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (!ok || o !== e) begin failures++; $display("FAIL hit_on_timeout: got %h required %h", o, e); end
        checks++;
        if (state !== 2'd3) begin failures++; $display("FAIL hit_on_timeout_state: state=%0d required 3", state); end
    endtask

    task automatic test_start_drop();
        bit ok;
        wait_armed(40, ok);
        cursor_x = ball_x; cursor_y = ball_y; trigger = 1'b1; start = 1'b0;
        tick();
        trigger = 1'b0;
        checks++;
        if (!ok || {state, target_visible, hit_pulse, miss_pulse, hits, misses} !==
            {2'd0, 1'b0, 1'b0, 1'b0, 7'(exp_hits), 7'(exp_misses)}) begin
            failures++;
            $display("FAIL start_drop: st=%0d vis=%b hp=%b mp=%b hits=%0d misses=%0d required 0 0 0 0 %0d %0d",
                     state, target_visible, hit_pulse, miss_pulse, hits, misses, exp_hits, exp_misses);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (state !== 2'd0 || hits !== 7'(exp_hits) || misses !== 7'(exp_misses)) begin
            failures++; $display("FAIL idle_hold: st=%0d hits=%0d misses=%0d required 0 %0d %0d",
                                 state, hits, misses, exp_hits, exp_misses);
        end
        start = 1'b1;
        tick();
        exp_hits = 0; exp_misses = 0;
        checks++;
        if (state !== 2'd1 || hits !== 7'd0 || misses !== 7'd0) begin
            failures++; $display("FAIL restart_clear: st=%0d hits=%0d misses=%0d required 1 0 0", state, hits, misses);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ev_t e, o;
        wait_armed(40, ok);
        cursor_x = ball_x; cursor_y = ball_y; trigger = 1'b1; push_expect(1'b1);
        tick();
        trigger = 1'b0;
        o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
        if (!ok || o !== e) begin failures++; $display("FAIL mid_hit: got %h required %h", o, e); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({ball_x, ball_y, target_visible, hit_pulse, hits, misses, state} !==
            {10'd320, 10'd240, 1'b0, 1'b0, 7'd0, 7'd0, 2'd0}) begin
            failures++;
            $display("FAIL async_reset: ball=(%0d,%0d) vis=%b hp=%b hits=%0d misses=%0d st=%0d required (320,240) 0 0 0 0 0",
                     ball_x, ball_y, target_visible, hit_pulse, hits, misses, state);
        end
        tick();
        rst = 1'b1;
        exp_hits = 0; exp_misses = 0;
    endtask

    task automatic test_saturation();
        bit ok;
        ev_t e, o;
        for (int i = 0; i < 100; i++) begin
            wait_armed(40, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL sat_arm: iteration %0d state=%0d required 2", i, state); break; end
            cursor_x = ball_x; cursor_y = ball_y; trigger = 1'b1; push_expect(1'b1);
            tick();
            trigger = 1'b0;
            o = {hit_pulse, miss_pulse, hits, misses}; e = sb.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL sat_hit: iteration %0d got %h required %h", i, o, e); end
        end
        checks++;
        if (hits !== 7'd99) begin failures++; $display("FAIL sat_final: hits=%0d required 99", hits); end
    endtask

    task automatic test_fallback();
        int n;
        start_b = 1'b1;
        tick();
        n = 0;
        while (state_b != 2'd2 && n < 30) begin n++; tick(); end
        checks++;
        if (n != 9) begin failures++; $display("FAIL fallback_dwell: spawn cycles=%0d required 9", n); end
        checks++;
        if (ball_x_b !== 10'd160 || ball_y_b !== 10'd240) begin
            failures++; $display("FAIL fallback_first: ball=(%0d,%0d) required (160,240)", ball_x_b, ball_y_b);
        end
        cursor_x_b = ball_x_b; cursor_y_b = ball_y_b; trigger_b = 1'b1;
        tick();
        trigger_b = 1'b0;
        checks++;
        if (hit_pulse_b !== 1'b1 || hits_b !== 7'd1) begin
            failures++; $display("FAIL fallback_hit: hp=%b hits=%0d required 1 1", hit_pulse_b, hits_b);
        end
        n = 0;
        while (state_b != 2'd2 && n < 40) begin n++; tick(); end
        checks++;
        if (state_b !== 2'd2 || ball_x_b !== 10'd480 || ball_y_b !== 10'd240) begin
            failures++;
            $display("FAIL fallback_second: st=%0d ball=(%0d,%0d) required 2 (480,240)", state_b, ball_x_b, ball_y_b);
        end
    endtask

    initial begin
        start = 1'b0; trigger = 1'b0; cursor_x = '0; cursor_y = '0;
        start_b = 1'b0; trigger_b = 1'b0; cursor_x_b = '0; cursor_y_b = '0;
        test_reset();
        test_hit();
        test_hitbox_edge();
        test_timeout();
        test_start_drop();
        test_reset_mid();
        test_saturation();
        test_fallback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
